// File: rtl/fft_stage_controller.sv
// ============================================================================
// Module   : fft_stage_controller
// Brief    : Radix-2 DIT FFT sequencer. Walks every stage and butterfly and
//            emits operand and twiddle addresses with a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_stage_controller #(
    parameter int LOG2_NFFT    = 5,
    parameter int DATA_WIDTH   = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           bf_ready,
    output logic                           bf_valid,
    output logic [LOG2_NFFT-1:0]           addr_a,
    output logic [LOG2_NFFT-1:0]           addr_b,
    output logic [DATA_WIDTH-1:0]          tw_addr,
    output logic [$clog2(LOG2_NFFT):0]     stage,
    output logic                           busy,
    output logic                           done
);

    localparam int SW = $clog2(LOG2_NFFT) + 1;

    localparam logic [SW-1:0]        c_last_stage = SW'(LOG2_NFFT - 1);
    localparam logic [LOG2_NFFT-2:0] c_last_beat  = '1;
    localparam logic [3:0]           c_drain_last = (DRAIN_CYCLES == 0) ? 4'd0
                                                  : 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state, w_state_n;
    logic [SW-1:0]          r_stage, w_stage_n;
    logic [LOG2_NFFT-2:0]   r_b, w_b_n;
    logic [3:0]             r_drain, w_drain_n;
    logic                   r_bf_valid, w_valid_n;
    logic                   r_busy, w_busy_n;
    logic                   r_done, w_done_n;
    logic [LOG2_NFFT-1:0]   r_addr_a, r_addr_b;
    logic [DATA_WIDTH-1:0]  r_tw_addr;

    logic [LOG2_NFFT-1:0]   w_b_ext, w_mask, w_pos, w_span, w_a, w_bb, w_tw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_stage_n = r_stage;
        w_b_n     = r_b;
        w_drain_n = r_drain;
        w_valid_n = 1'b0;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_n = S_RUN;
                    w_stage_n = '0;
                    w_b_n     = '0;
                    w_valid_n = 1'b1;
                    w_busy_n  = 1'b1;
                end
            end
            S_RUN: begin
                w_valid_n = 1'b1;
                if (bf_ready) begin
                    if (r_b == c_last_beat) begin
                        w_b_n     = '0;
                        w_drain_n = '0;
                        w_valid_n = 1'b0;
                        w_state_n = S_DRAIN;
                    end else begin
                        w_b_n = r_b + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                w_drain_n = r_drain + 1'b1;
                // With no drain requested the stage boundary still costs one cycle
                if (r_drain >= c_drain_last) begin
                    w_drain_n = '0;
                    if (r_stage == c_last_stage) begin
                        w_state_n = S_DONE;
                        w_done_n  = 1'b1;
                        w_busy_n  = 1'b0;
                    end else begin
                        w_state_n = S_RUN;
                        w_stage_n = r_stage + 1'b1;
                        w_valid_n = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
                w_stage_n = '0;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Addresses for the beat that will be presented next cycle:
    // addr_a = (group << (s+1)) | pos, i.e. the group bits shifted up by one.
    always_comb begin
        w_b_ext = {1'b0, w_b_n};
        w_mask  = ~({LOG2_NFFT{1'b1}} << w_stage_n);
        w_pos   = w_b_ext & w_mask;
        w_span  = {{(LOG2_NFFT-1){1'b0}}, 1'b1} << w_stage_n;
        w_a     = ((w_b_ext & ~w_mask) << 1) | w_pos;
        w_bb    = w_a | w_span;
        w_tw    = w_pos << (c_last_stage - w_stage_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage    <= '0;
            r_b        <= '0;
            r_drain    <= '0;
            r_bf_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_tw_addr  <= '0;
        end else begin
            r_stage    <= w_stage_n;
            r_b        <= w_b_n;
            r_drain    <= w_drain_n;
            r_bf_valid <= w_valid_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
            if (w_valid_n) begin
                r_addr_a  <= w_a;
                r_addr_b  <= w_bb;
                r_tw_addr <= {{(DATA_WIDTH-LOG2_NFFT){1'b0}}, w_tw};
            end else begin
                r_addr_a  <= '0;
                r_addr_b  <= '0;
                r_tw_addr <= '0;
            end
        end
    end

    assign bf_valid = r_bf_valid;
    assign addr_a   = r_addr_a;
    assign addr_b   = r_addr_b;
    assign tw_addr  = r_tw_addr;
    assign stage    = r_stage;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_fft_stage_controller.sv
// ============================================================================
// Module   : tb_fft_stage_controller
// Brief    : Self-checking bench: beat-order model, latency and reset checks.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft_stage_controller;

    localparam int L    = 5;
    localparam int DW   = 16;
    localparam int NB   = 80;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          start1 = 1'b0;
    logic          bf_ready = 1'b1;
    logic          bf_valid, busy, done;
    logic [L-1:0]  addr_a, addr_b;
    logic [DW-1:0] tw_addr;
    logic [3:0]    stage;
    logic          z_bf_valid, z_busy, z_done;
    logic [L-1:0]  z_addr_a, z_addr_b;
    logic [DW-1:0] z_tw_addr;
    logic [3:0]    z_stage;

    fft_stage_controller #(.LOG2_NFFT(L), .DATA_WIDTH(DW), .DRAIN_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bf_ready(bf_ready),
        .bf_valid(bf_valid), .addr_a(addr_a), .addr_b(addr_b), .tw_addr(tw_addr),
        .stage(stage), .busy(busy), .done(done)
    );

    fft_stage_controller #(.LOG2_NFFT(L), .DATA_WIDTH(DW), .DRAIN_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bf_ready(1'b1),
        .bf_valid(z_bf_valid), .addr_a(z_addr_a), .addr_b(z_addr_b), .tw_addr(z_tw_addr),
        .stage(z_stage), .busy(z_busy), .done(z_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected beat sequence, one entry per butterfly in execution order
    int ea[NB], eb[NB], et[NB], es[NB];
    initial begin
        for (int s = 0; s < L; s++) begin
            for (int b = 0; b < 16; b++) begin
                int span, grp, pos, k;
                span  = 2 ** s;
                grp   = b / span;
                pos   = b % span;
                k     = s * 16 + b;
                ea[k] = grp * 2 * span + pos;
                eb[k] = ea[k] + span;
                et[k] = pos * (16 / span);
                es[k] = s;
            end
        end
    end

    int idx = 0;
    bit check_en = 1'b0;
    logic [31:0] cap_a[4], cap_b[4], cap_t[4], cap_s[4];

    always @(negedge clk) begin
        if (check_en && rst_n && bf_valid) begin
            if (idx >= NB) begin
                chk("beat_overrun", idx, NB - 1);
            end else begin
                chk($sformatf("addr_a[%0d]", idx), addr_a, ea[idx]);
                chk($sformatf("addr_b[%0d]", idx), addr_b, eb[idx]);
                chk($sformatf("tw_addr[%0d]", idx), tw_addr, et[idx]);
                chk($sformatf("stage[%0d]", idx), stage, es[idx]);
                case (idx)
                    0:  begin cap_a[0] = addr_a; cap_b[0] = addr_b; cap_t[0] = tw_addr; cap_s[0] = stage; end
                    17: begin cap_a[1] = addr_a; cap_b[1] = addr_b; cap_t[1] = tw_addr; cap_s[1] = stage; end
                    37: begin cap_a[2] = addr_a; cap_b[2] = addr_b; cap_t[2] = tw_addr; cap_s[2] = stage; end
                    79: begin cap_a[3] = addr_a; cap_b[3] = addr_b; cap_t[3] = tw_addr; cap_s[3] = stage; end
                    default: ;
                endcase
            end
            if (bf_ready) idx++;
        end
    end

    task automatic run_fft(input int exp_lat, input int stall_at,
                           input bit pulse_run, input bit pulse_done);
        int t0;
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        idx   = 0;
        start = 1'b1;
        t0    = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            int rel;
            @(posedge clk); #1;
            rel      = cyc - t0;
            bf_ready = !(stall_at > 0 && rel >= stall_at && rel < stall_at + 3);
            start    = pulse_run && (rel == 10 || rel == 55);
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            chk("busy_during_run", busy, 1'b1);
        end
        bf_ready = 1'b1;
        start    = 1'b0;
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("done_latency", cyc - t0, exp_lat);
            chk("beat_count", idx, NB);
            chk("busy_in_done", busy, 1'b0);
            if (pulse_done) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("done_one_cycle", done, 1'b0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("idle_after_done_valid", bf_valid, 1'b0);
                chk("idle_after_done_busy", busy, 1'b0);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bf_valid"}, bf_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_addr_a"}, addr_a, 0);
        chk({tag, "_addr_b"}, addr_b, 0);
        chk({tag, "_tw_addr"}, tw_addr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int beats, t0;
        bit seen;

        #23;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n    = 1'b1;
        check_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_start_busy", busy, 1'b0);

        // Nominal run
        run_fft(100, 0, 1'b0, 1'b0);
        chk("model_s1b1_a", ea[17], 1);
        chk("model_s2b5_b", eb[37], 13);
        chk("model_s4b15_t", et[79], 15);
        chk("first_a", cap_a[0], 0);   chk("first_b", cap_b[0], 1);
        chk("first_t", cap_t[0], 0);   chk("first_s", cap_s[0], 0);
        chk("s1b1_a", cap_a[1], 1);    chk("s1b1_b", cap_b[1], 3);
        chk("s1b1_t", cap_t[1], 8);    chk("s1b1_s", cap_s[1], 1);
        chk("s2b5_a", cap_a[2], 9);    chk("s2b5_b", cap_b[2], 13);
        chk("s2b5_t", cap_t[2], 4);    chk("s2b5_s", cap_s[2], 2);
        chk("s4b15_a", cap_a[3], 15);  chk("s4b15_b", cap_b[3], 31);
        chk("s4b15_t", cap_t[3], 15);  chk("s4b15_s", cap_s[3], 4);

        // Three-cycle stall in the middle of stage 1
        run_fft(103, 30, 1'b0, 1'b0);

        // Start re-pulsed during RUN and in the DONE cycle
        run_fft(100, 0, 1'b1, 1'b1);

        // Asynchronous reset during stage 2
        @(posedge clk); #1;
        idx   = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (stage == 4'd2 && bf_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("reach_stage2", seen, 1'b1);
        repeat (3) @(negedge clk);
        #2;
        check_en = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_valid", bf_valid, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
        end
        check_en = 1'b1;
        run_fft(100, 0, 1'b0, 1'b0);

        // Zero drain cycles on the second instance
        @(posedge clk); #1;
        start1 = 1'b1;
        t0     = cyc + 1;
        @(posedge clk); #1;
        start1 = 1'b0;
        beats  = 0;
        seen   = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (z_done) begin
                seen = 1'b1;
                break;
            end
            if (z_bf_valid) begin
                if (beats == 0) begin
                    chk("z_first_a", z_addr_a, 0);
                    chk("z_first_b", z_addr_b, 1);
                end
                if (beats == 79) begin
                    chk("z_last_b", z_addr_b, 31);
                    chk("z_last_t", z_tw_addr, 15);
                    chk("z_last_s", z_stage, 4);
                end
                beats++;
            end
        end
        chk("z_done_seen", seen, 1'b1);
        chk("z_done_latency", cyc - t0, 85);
        chk("z_beat_count", beats, NB);
        chk("z_busy_in_done", z_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fft_stage_controller.md
FFT_STAGE_CONTROLLER -- requirements
Module: fft_stage_controller

Interface
REQ-001: Parameter LOG2_NFFT, default 5, SHALL set log2 of the FFT size: N = 2**LOG2_NFFT points and LOG2_NFFT stages.
REQ-002: Parameter DATA_WIDTH, default 16, SHALL set the width of tw_addr, matching the twiddle ROM address port.
REQ-003: Parameter DRAIN_CYCLES, default 4, SHALL set the number of idle cycles between stages (butterfly pipeline flush), range 0..15.
REQ-004: clk  in  1  single clock; all state updates on the rising edge.
REQ-005: rst_n  in  1  asynchronous, active-low reset.
REQ-006: start  in  1  one-cycle request to run one full FFT.
REQ-007: bf_ready  in  1  butterfly unit accepts the current beat.
REQ-008: bf_valid  out  1  addr_a, addr_b and tw_addr are valid.
REQ-009: addr_a  out  LOG2_NFFT  upper butterfly operand address.
REQ-010: addr_b  out  LOG2_NFFT  lower butterfly operand address.
REQ-011: tw_addr  out  DATA_WIDTH  twiddle ROM address, zero-extended.
REQ-012: stage  out  ceil(log2(LOG2_NFFT))+1  current stage index s.
REQ-013: busy  out  1  high from start acceptance until done.
REQ-014: done  out  1  one-cycle pulse when the FFT completes.

Function
REQ-015: The FSM SHALL have the states IDLE, RUN, DRAIN and DONE; all outputs SHALL be registered.
REQ-016: IDLE->RUN on start=1; stage=0, butterfly counter b=0, busy=1 from the next cycle.
REQ-017: start while not in IDLE SHALL be ignored, with no effect on any counter.
REQ-018: In RUN, bf_valid=1; a beat SHALL be accepted on an edge with bf_valid=1 and bf_ready=1.
REQ-019: While bf_valid=1 and bf_ready=0, addr_a, addr_b, tw_addr and stage SHALL hold stable.
REQ-020: Per beat, with span=2**s, group=b>>s and pos=b&(span-1): addr_a=(group<<(s+1))|pos, addr_b=addr_a+span, tw_addr=pos<<(LOG2_NFFT-1-s).
REQ-021: b SHALL range 0..N/2-1 and increment by 1 per accepted beat.
REQ-022: Acceptance of beat b=N/2-1 SHALL clear b, drive bf_valid=0 and enter DRAIN.
REQ-023: DRAIN SHALL last exactly DRAIN_CYCLES cycles, then go to RUN with stage+1, or to DONE if s was LOG2_NFFT-1.
REQ-024: With DRAIN_CYCLES=0, the controller SHALL leave DRAIN after one cycle.
REQ-025: DONE SHALL last one cycle with done=1 and busy=0, then go to IDLE.
REQ-026: A start arriving in the DONE cycle SHALL be ignored.
REQ-027: tw_addr SHALL never exceed N/2-1.
REQ-028: Bits of tw_addr above LOG2_NFFT-1 SHALL be 0.

Reset
REQ-029: While rst_n=0 the block SHALL be in IDLE with bf_valid=0, busy=0, done=0, stage=0, addr_a=0, addr_b=0, tw_addr=0 and all counters 0.
REQ-030: rst_n deassertion mid-operation SHALL resume in IDLE and SHALL require a new start.

Verification
REQ-031: N=32, bf_ready=1, start pulse -> first beat addr_a=0, addr_b=1, tw_addr=0, stage=0; done pulses on the 100th edge after the start edge (5 stages x (16 beats + 4 drain)).
REQ-032: Stage 1, b=1 -> addr_a=1, addr_b=3, tw_addr=8; stage 2, b=5 -> addr_a=9, addr_b=13, tw_addr=4; stage 4, b=15 -> addr_a=15, addr_b=31, tw_addr=15.
REQ-033: bf_ready low for 3 cycles mid-stage -> outputs frozen during the stall, no beat skipped or repeated, done delayed by exactly 3 cycles.
REQ-034: start re-pulsed during RUN and during DONE -> ignored, with exactly 80 accepted beats per run.
REQ-035: rst_n low during stage 2 -> all outputs 0 asynchronously; after release the block stays IDLE until start.
REQ-036: DRAIN_CYCLES=0 -> one idle cycle per stage boundary; done on the 85th edge after the start edge.
